// File: rtl/phase_sweep_gen.sv
// Chirp phase generator: sweeps a phase accumulator's frequency linearly per
// sample and streams N sin/cos table indices over a valid/ready handshake.
module phase_sweep_gen #(
  parameter int PHASE_WIDTH = 32,
  parameter int ANGLE_WIDTH = 10,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PHASE_WIDTH-1:0] freq_start,
  input  logic [PHASE_WIDTH-1:0] freq_step,
  input  logic [ANGLE_WIDTH-1:0] phase_offset,
  input  logic [COUNT_WIDTH-1:0] num_samples,
  output logic [ANGLE_WIDTH-1:0] angle_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q;
  logic [PHASE_WIDTH-1:0] acc_q, freq_q, step_q;
  logic [ANGLE_WIDTH-1:0] off_q, angle_q;
  logic [COUNT_WIDTH-1:0] n_q, cnt_q;
  logic                   valid_q, busy_q, done_q;

  logic [PHASE_WIDTH-1:0] acc_d, freq_d;
  logic [COUNT_WIDTH-1:0] cnt_d;
  logic [ANGLE_WIDTH-1:0] angle_d;
  logic                   accept;

  // Next-sample values; the index is registered alongside the accumulator so
  // angle_out never sees a combinational path from the inputs.
  assign acc_d   = acc_q + freq_q;
  assign freq_d  = freq_q + step_q;
  assign cnt_d   = cnt_q + CNT_ONE;
  assign angle_d = acc_d[PHASE_WIDTH-1 -: ANGLE_WIDTH] + off_q;
  assign accept  = valid_q & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      freq_q  <= '0;
      step_q  <= '0;
      off_q   <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      angle_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (abort) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            acc_q   <= '0;
            freq_q  <= freq_start;
            step_q  <= freq_step;
            off_q   <= phase_offset;
            n_q     <= num_samples;
            cnt_q   <= '0;
            angle_q <= phase_offset;
            if (num_samples != '0) begin
              state_q <= ST_RUN;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              // Empty run: skip straight to the completion pulse.
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            acc_q   <= acc_d;
            freq_q  <= freq_d;
            cnt_q   <= cnt_d;
            angle_q <= angle_d;
            if (cnt_d == n_q) begin
              state_q <= ST_DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign angle_out = angle_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_phase_sweep_gen.sv
// Bench for phase_sweep_gen: directed and random runs compared against a
// closed-form chirp phase model, with random and directed backpressure.
module tb_phase_sweep_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] freq_start = '0;
  logic [31:0] freq_step = '0;
  logic [9:0]  phase_offset = '0;
  logic [15:0] num_samples = '0;
  logic [9:0]  angle_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  phase_sweep_gen #(.PHASE_WIDTH(32), .ANGLE_WIDTH(10), .COUNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .freq_start(freq_start), .freq_step(freq_step), .phase_offset(phase_offset),
    .num_samples(num_samples), .angle_out(angle_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sample k phase = k*f0 + step*k(k-1)/2 (mod 2^32); index = top 10 bits + offset.
  function automatic logic [9:0] model(input logic [31:0] f0, input logic [31:0] st,
                                       input logic [9:0] off, input int k);
    longint unsigned kk;
    longint unsigned ph;
    logic [31:0] p;
    kk = longint'(k);
    ph = kk * longint'(f0) + longint'(st) * ((kk * (kk - 1)) / 2);
    p = ph[31:0];
    return p[31:22] + off;
  endfunction

  task automatic idle_checks(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy},      32'd0);
    chk({tag, "_done"},  {31'd0, done},      32'd0);
  endtask

  // One run: stall_pct = random ready-low probability, hold_at = sample index at
  // which ready is held low for 3 cycles (-1 none), abort_at = abort once this
  // many samples were accepted (-1 none), poke = pulse start mid-run.
  task automatic do_run(input string tag, input logic [31:0] f0, input logic [31:0] st,
                        input logic [9:0] off, input int n, input int stall_pct,
                        input int hold_at, input int abort_at, input bit poke);
    int k;
    int cyc;
    int held;
    bit rdy;
    @(negedge clk);
    freq_start = f0; freq_step = st; phase_offset = off; num_samples = 16'(n);
    start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 0; cyc = 0; held = 0;
    while (k < n && cyc < 2000) begin
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_busy"},  {31'd0, busy},      32'd1);
      chk({tag, "_done"},  {31'd0, done},      32'd0);
      chk({tag, "_angle"}, {22'd0, angle_out}, {22'd0, model(f0, st, off, k)});
      if (k == abort_at) begin
        abort = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        idle_checks({tag, "_abort"});
        @(negedge clk);
        idle_checks({tag, "_after_abort"});
        return;
      end
      if (poke && cyc == 1) begin
        start = 1'b1; freq_start = $urandom; freq_step = $urandom;
        phase_offset = 10'($urandom); num_samples = 16'd1;
      end else begin
        start = 1'b0;
      end
      if (k == hold_at && held < 3) begin
        rdy = 1'b0; held++;
      end else begin
        rdy = ($urandom_range(99) >= stall_pct);
      end
      out_ready = rdy;
      @(negedge clk);
      if (rdy) k++;
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_accepts"}, 32'(k), 32'(n));
    out_ready = $urandom_range(1);
    chk({tag, "_end_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_end_busy"},  {31'd0, busy},      32'd0);
    chk({tag, "_end_done"},  {31'd0, done},      32'd1);
    @(negedge clk);
    idle_checks({tag, "_post"});
  endtask

  initial begin
    #2;
    chk("reset_angle", {22'd0, angle_out}, 32'd0);
    idle_checks("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_run("tone",  32'h0040_0000, 32'd0,          10'd0,    4, 0, -1, -1, 1'b0);
    do_run("chirp", 32'd0,         32'h0040_0000,  10'd0,    5, 0, -1, -1, 1'b0);
    do_run("wrap",  32'h0040_0000, 32'd0,          10'd1020, 6, 0, -1, -1, 1'b0);
    do_run("bp",    32'h0040_0000, 32'd0,          10'd0,    4, 0,  2, -1, 1'b0);
    do_run("poke",  32'h0040_0000, 32'd0,          10'd7,    5, 0, -1, -1, 1'b1);
    do_run("down",  32'h1000_0000, 32'hFF80_0000,  10'd3,   12, 20, -1, -1, 1'b0);

    // Empty run: done one cycle after start, never valid.
    @(negedge clk);
    num_samples = 16'd0; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("n0_done",  {31'd0, done},      32'd1);
    chk("n0_valid", {31'd0, out_valid}, 32'd0);
    chk("n0_busy",  {31'd0, busy},      32'd0);
    @(negedge clk);
    idle_checks("n0_post");

    do_run("abort", 32'h0040_0000, 32'd0, 10'd0, 4, 0, -1, 2, 1'b0);

    // abort together with start in IDLE: no run begins.
    @(negedge clk);
    num_samples = 16'd3; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    idle_checks("abort_start");
    @(negedge clk);
    idle_checks("abort_start2");

    // Reset mid-run clears outputs immediately.
    freq_start = 32'h0040_0000; freq_step = '0; phase_offset = 10'd9;
    num_samples = 16'd8; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_angle", {22'd0, angle_out}, 32'd11);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_angle", {22'd0, angle_out}, 32'd0);
    idle_checks("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    do_run("restart", 32'h0040_0000, 32'd0, 10'd5, 3, 0, -1, -1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      do_run("rand", $urandom, $urandom, 10'($urandom), int'($urandom_range(20, 1)),
             30, -1, -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

endmodule
